// File: rtl/serial_cmd_tx.sv
// Command word serializer: a DEPTH-entry FIFO feeds a framing FSM that sends each
// word as start beat, MSB-first data beats, optional even-parity beat and an idle gap.
module serial_cmd_tx #(
  parameter int LENGTH    = 32,
  parameter int LINES     = 1,
  parameter int DEPTH     = 4,
  parameter int PARITY    = 0,
  parameter int IDLE_BITS = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid,
  output logic                       ready,
  input  logic [LENGTH-1:0]          data_in,
  output logic [LINES-1:0]           d,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int BEATS  = LENGTH / LINES;
  localparam int LVL_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BEAT_W = $clog2(BEATS + 1);
  localparam int GAP_W  = (IDLE_BITS > 0) ? $clog2(IDLE_BITS + 1) : 1;

  // S_START_NEXT is the decision point after a frame: pop the next word or fall idle.
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_DATA       = 3'd1,
    S_PAR        = 3'd2,
    S_GAP        = 3'd3,
    S_START_NEXT = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [LENGTH-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                ready_q;
  logic [LENGTH-1:0]   sr_q, sr_d;
  logic [LINES-1:0]    par_q, par_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [LINES-1:0]    dout_q, dout_d;
  logic                busy_q, busy_d;
  logic                push_s;
  logic                pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + 1'b1;
    end
  endfunction

  assign push_s = valid && ready_q;
  assign ready  = ready_q;
  assign d      = dout_q;
  assign busy   = busy_q;
  assign level  = level_q;

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s && !pop_s) begin
      level_d = level_q + 1'b1;
    end else if (pop_s && !push_s) begin
      level_d = level_q - 1'b1;
    end else begin
      level_d = level_q;
    end
  end

  // Framing FSM next-state and next output beat
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    par_d   = par_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    dout_d  = dout_q;
    busy_d  = busy_q;
    pop_s   = 1'b0;
    case (state_q)
      S_IDLE, S_START_NEXT: begin
        if (level_q != '0) begin
          pop_s   = 1'b1;
          sr_d    = mem_q[rd_ptr_q];
          par_d   = '0;
          beat_d  = '0;
          dout_d  = '1;
          busy_d  = 1'b1;
          state_d = S_DATA;
        end else begin
          dout_d  = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        dout_d = sr_q[LENGTH-1 -: LINES];
        par_d  = par_q ^ sr_q[LENGTH-1 -: LINES];
        sr_d   = sr_q << LINES;
        beat_d = beat_q + 1'b1;
        if (int'(beat_q) == BEATS - 1) begin
          if (PARITY != 0) begin
            state_d = S_PAR;
          end else if (IDLE_BITS != 0) begin
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            state_d = S_START_NEXT;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PAR: begin
        dout_d = par_q;
        if (IDLE_BITS != 0) begin
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          state_d = S_START_NEXT;
        end
      end
      S_GAP: begin
        dout_d = '0;
        gap_d  = gap_q + 1'b1;
        if (int'(gap_q) == IDLE_BITS - 1) begin
          state_d = S_START_NEXT;
        end else begin
          state_d = S_GAP;
        end
      end
      default: begin
        dout_d  = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO storage; contents need no reset because the pointers and level do
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // State, FIFO bookkeeping and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b0;
      sr_q     <= '0;
      par_q    <= '0;
      beat_q   <= '0;
      gap_q    <= '0;
      dout_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ready_q  <= (int'(level_d) < DEPTH);
      sr_q     <= sr_d;
      par_q    <= par_d;
      beat_q   <= beat_d;
      gap_q    <= gap_d;
      dout_q   <= dout_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_serial_cmd_tx.sv
// Bench for serial_cmd_tx: five differently parametrised instances checked every cycle
// against a queue-of-beats reference model, plus directed frames with literal patterns.
module tb_serial_cmd_tx;

  localparam int NI = 5;
  localparam int FD = 256;
  localparam int BD = 64;
  localparam int CD = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int lines_c [NI] = '{1, 4, 4, 8, 2};
  int par_c   [NI] = '{0, 0, 1, 1, 0};
  int gap_c   [NI] = '{2, 2, 2, 0, 0};
  int depth_c [NI] = '{4, 4, 4, 3, 1};

  logic        valid_v [NI];
  logic [31:0] data_v  [NI];
  logic        ready_v [NI];
  logic        busy_v  [NI];
  logic [7:0]  act_d   [NI];
  int          act_lvl [NI];

  logic [0:0] d0;
  logic [3:0] d1, d2;
  logic [7:0] d3;
  logic [1:0] d4;
  logic [2:0] l0, l1, l2;
  logic [1:0] l3;
  logic [0:0] l4;

  serial_cmd_tx #(.LENGTH(32), .LINES(1), .DEPTH(4), .PARITY(0), .IDLE_BITS(2)) u0 (
    .clk(clk), .rst_n(rst_n), .valid(valid_v[0]), .ready(ready_v[0]), .data_in(data_v[0]),
    .d(d0), .busy(busy_v[0]), .level(l0));
  serial_cmd_tx #(.LENGTH(32), .LINES(4), .DEPTH(4), .PARITY(0), .IDLE_BITS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .valid(valid_v[1]), .ready(ready_v[1]), .data_in(data_v[1]),
    .d(d1), .busy(busy_v[1]), .level(l1));
  serial_cmd_tx #(.LENGTH(32), .LINES(4), .DEPTH(4), .PARITY(1), .IDLE_BITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .valid(valid_v[2]), .ready(ready_v[2]), .data_in(data_v[2]),
    .d(d2), .busy(busy_v[2]), .level(l2));
  serial_cmd_tx #(.LENGTH(32), .LINES(8), .DEPTH(3), .PARITY(1), .IDLE_BITS(0)) u3 (
    .clk(clk), .rst_n(rst_n), .valid(valid_v[3]), .ready(ready_v[3]), .data_in(data_v[3]),
    .d(d3), .busy(busy_v[3]), .level(l3));
  serial_cmd_tx #(.LENGTH(32), .LINES(2), .DEPTH(1), .PARITY(0), .IDLE_BITS(0)) u4 (
    .clk(clk), .rst_n(rst_n), .valid(valid_v[4]), .ready(ready_v[4]), .data_in(data_v[4]),
    .d(d4), .busy(busy_v[4]), .level(l4));

  assign act_d[0] = {7'd0, d0};
  assign act_d[1] = {4'd0, d1};
  assign act_d[2] = {4'd0, d2};
  assign act_d[3] = d3;
  assign act_d[4] = {6'd0, d4};
  assign act_lvl[0] = int'(l0);
  assign act_lvl[1] = int'(l1);
  assign act_lvl[2] = int'(l2);
  assign act_lvl[3] = int'(l3);
  assign act_lvl[4] = int'(l4);

  // Reference model: a word FIFO plus a queue of beats still to appear on the lanes.
  logic [31:0] fmem [NI][FD];
  int          fhead [NI];
  int          ftail [NI];
  logic [7:0]  bmem [NI][BD];
  int          bhead [NI];
  int          btail [NI];
  logic [7:0]  exp_d    [NI];
  logic        exp_busy [NI];
  logic        exp_rdy  [NI];
  int          exp_lvl  [NI];
  logic        pushed_m [NI];

  logic        cap_en;
  logic [7:0]  cap_d [NI][CD];
  logic        cap_b [NI][CD];
  int          cap_n [NI];

  int n_checks;
  int n_errors;

  task automatic check_val(input string tag, input int act_v, input int exp_v);
    n_checks++;
    if (act_v != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act_v, exp_v, $time);
    end
  endtask

  task automatic add_beat(input int i, input logic [7:0] b);
    bmem[i][btail[i] % BD] = b;
    btail[i]++;
  endtask

  task automatic build_frame(input int i, input logic [31:0] w);
    int L;
    int nb;
    logic [7:0] mask;
    logic [7:0] ch;
    logic [7:0] par;
    L    = lines_c[i];
    nb   = 32 / L;
    mask = 8'((1 << L) - 1);
    par  = 8'h00;
    add_beat(i, mask);
    for (int k = 0; k < nb; k++) begin
      ch  = 8'(w >> (32 - (k + 1) * L)) & mask;
      par = par ^ ch;
      add_beat(i, ch);
    end
    if (par_c[i] != 0) add_beat(i, par);
    for (int g = 0; g < gap_c[i]; g++) add_beat(i, 8'h00);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      fhead[i] = 0; ftail[i] = 0; bhead[i] = 0; btail[i] = 0;
      exp_d[i] = 8'h00; exp_busy[i] = 1'b0; exp_rdy[i] = 1'b0; exp_lvl[i] = 0;
      pushed_m[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      pushed_m[i] = 1'b0;
      if (bhead[i] == btail[i] && ftail[i] != fhead[i]) begin
        build_frame(i, fmem[i][fhead[i] % FD]);
        fhead[i]++;
      end
      if (bhead[i] != btail[i]) begin
        exp_d[i]    = bmem[i][bhead[i] % BD];
        exp_busy[i] = 1'b1;
        bhead[i]++;
      end else begin
        exp_d[i]    = 8'h00;
        exp_busy[i] = 1'b0;
      end
      if (valid_v[i] && exp_rdy[i]) begin
        fmem[i][ftail[i] % FD] = data_v[i];
        ftail[i]++;
        pushed_m[i] = 1'b1;
      end
      exp_lvl[i] = ftail[i] - fhead[i];
      exp_rdy[i] = (exp_lvl[i] < depth_c[i]);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      check_val($sformatf("d_%0d", i), int'(act_d[i]), int'(exp_d[i]));
      check_val($sformatf("busy_%0d", i), int'(busy_v[i]), int'(exp_busy[i]));
      check_val($sformatf("level_%0d", i), act_lvl[i], exp_lvl[i]);
      check_val($sformatf("ready_%0d", i), int'(ready_v[i]), int'(exp_rdy[i]));
      if (cap_en && cap_n[i] < CD) begin
        cap_d[i][cap_n[i]] = act_d[i];
        cap_b[i][cap_n[i]] = busy_v[i];
        cap_n[i]++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic cap_start();
    for (int i = 0; i < NI; i++) cap_n[i] = 0;
    cap_en = 1'b1;
  endtask

  // Literal frame pattern, nb beats of lines_c[i] bits, starting at capture index off.
  task automatic check_pattern(input int i, input string tag, input logic [63:0] pat,
                               input int nb, input int off);
    int L;
    int busy_cnt;
    logic [63:0] mask;
    L = lines_c[i];
    mask = (64'd1 << L) - 64'd1;
    busy_cnt = 0;
    for (int k = 0; k < nb; k++) begin
      check_val($sformatf("%s_beat%0d", tag, k), int'(cap_d[i][off + k]),
                int'((pat >> ((nb - 1 - k) * L)) & mask));
    end
    for (int k = 0; k < cap_n[i]; k++) begin
      if (cap_b[i][k]) busy_cnt++;
    end
    check_val($sformatf("%s_busy_cycles", tag), busy_cnt, nb);
    check_val($sformatf("%s_after", tag), int'(cap_d[i][off + nb]), 0);
  endtask

  // Start + data beats of word w (no parity) at capture index off.
  task automatic check_frame_at(input int i, input string tag, input int off, input logic [31:0] w);
    int L;
    int nb;
    L  = lines_c[i];
    nb = 32 / L;
    check_val($sformatf("%s_start", tag), int'(cap_d[i][off]), (1 << L) - 1);
    check_val($sformatf("%s_start_busy", tag), int'(cap_b[i][off]), 1);
    for (int k = 0; k < nb; k++) begin
      check_val($sformatf("%s_beat%0d", tag, k), int'(cap_d[i][off + 1 + k]),
                int'((w >> (32 - (k + 1) * L)) & ((32'd1 << L) - 32'd1)));
    end
    for (int g = 0; g < gap_c[i]; g++) begin
      check_val($sformatf("%s_gap%0d", tag, g), int'(cap_d[i][off + 1 + nb + g]), 0);
    end
  endtask

  task automatic async_reset();
    for (int i = 0; i < NI; i++) valid_v[i] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check_val($sformatf("rst_d_%0d", i), int'(act_d[i]), 0);
      check_val($sformatf("rst_busy_%0d", i), int'(busy_v[i]), 0);
      check_val($sformatf("rst_level_%0d", i), act_lvl[i], 0);
      check_val($sformatf("rst_ready_%0d", i), int'(ready_v[i]), 0);
    end
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  logic [31:0] w6 [6];
  logic [31:0] wa;
  logic [31:0] wb;
  int idx;
  int max_lvl;
  int saw_nready;

  initial begin
    n_checks = 0;
    n_errors = 0;
    cap_en = 1'b0;
    for (int i = 0; i < NI; i++) begin
      valid_v[i] = 1'b0; data_v[i] = 32'd0; cap_n[i] = 0;
    end
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    step();

    // Single frames with literal expectations, latency 1 from the push edge
    valid_v[0] = 1'b1; data_v[0] = 32'hF000_0000;
    valid_v[1] = 1'b1; data_v[1] = 32'h1234_5678;
    valid_v[2] = 1'b1; data_v[2] = 32'hFFFF_FFFF;
    step();
    for (int i = 0; i < NI; i++) valid_v[i] = 1'b0;
    cap_start();
    repeat (40) step();
    cap_en = 1'b0;
    check_pattern(0, "f000", 64'({1'b1, 32'hF000_0000, 2'b00}), 35, 0);
    check_pattern(1, "x1234", 64'({4'hF, 32'h1234_5678, 8'h00}), 11, 0);
    check_pattern(2, "par_ones", 64'({4'hF, 32'hFFFF_FFFF, 4'h0, 8'h00}), 12, 0);

    valid_v[2] = 1'b1; data_v[2] = 32'h0000_0001;
    step();
    valid_v[2] = 1'b0;
    cap_start();
    repeat (16) step();
    cap_en = 1'b0;
    check_pattern(2, "par_one", 64'({4'hF, 32'h0000_0001, 4'h1, 8'h00}), 12, 0);

    // Six words with valid held: back-to-back frames, FIFO fills, ready drops
    for (int k = 0; k < 6; k++) w6[k] = ($urandom() & 32'hFFFF_FFF0) | 32'(k);
    idx = 0; max_lvl = 0; saw_nready = 0;
    valid_v[0] = 1'b1; data_v[0] = w6[0];
    cap_start();
    for (int c = 0; c < 230; c++) begin
      step();
      if (pushed_m[0]) begin
        idx++;
        if (idx < 6) data_v[0] = w6[idx];
        else valid_v[0] = 1'b0;
      end
      if (!ready_v[0]) saw_nready = 1;
      if (act_lvl[0] > max_lvl) max_lvl = act_lvl[0];
    end
    cap_en = 1'b0;
    check_val("six_accepted", idx, 6);
    check_val("six_max_level", max_lvl, 4);
    check_val("six_ready_fell", saw_nready, 1);
    check_val("six_pre_start", int'(cap_d[0][0]), 0);
    for (int k = 0; k < 6; k++) check_frame_at(0, $sformatf("six%0d", k), 1 + 35 * k, w6[k]);
    check_val("six_end_busy", int'(cap_b[0][211]), 0);

    // IDLE_BITS=0: second start beat directly follows the last data beat
    wa = $urandom(); wb = $urandom();
    idx = 0;
    valid_v[4] = 1'b1; data_v[4] = wa;
    cap_start();
    for (int c = 0; c < 40; c++) begin
      step();
      if (pushed_m[4]) begin
        idx++;
        if (idx < 2) data_v[4] = wb;
        else valid_v[4] = 1'b0;
      end
    end
    cap_en = 1'b0;
    check_val("gap0_accepted", idx, 2);
    check_frame_at(4, "gap0_a", 1, wa);
    check_frame_at(4, "gap0_b", 18, wb);
    check_val("gap0_end_busy", int'(cap_b[4][35]), 0);

    // Reset in the middle of a frame with two words queued
    idx = 0;
    valid_v[0] = 1'b1; data_v[0] = $urandom();
    for (int c = 0; c < 20 && idx < 3; c++) begin
      step();
      if (pushed_m[0]) begin
        idx++;
        if (idx < 3) data_v[0] = $urandom();
        else valid_v[0] = 1'b0;
      end
    end
    valid_v[0] = 1'b0;
    check_val("rst_pushes", idx, 3);
    repeat (8) step();
    check_val("pre_rst_level", act_lvl[0], 2);
    check_val("pre_rst_busy", int'(busy_v[0]), 1);
    async_reset();
    repeat (45) step();
    valid_v[0] = 1'b1; data_v[0] = 32'hF000_0000;
    step();
    valid_v[0] = 1'b0;
    cap_start();
    repeat (40) step();
    cap_en = 1'b0;
    check_pattern(0, "post_rst", 64'({1'b1, 32'hF000_0000, 2'b00}), 35, 0);

    // Random traffic on every instance, one asynchronous reset midway
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) async_reset();
      step();
      for (int i = 0; i < NI; i++) begin
        if (valid_v[i] && pushed_m[i]) valid_v[i] = 1'b0;
        if (!valid_v[i] && $urandom_range(0, 3) == 0) begin
          valid_v[i] = 1'b1;
          data_v[i]  = $urandom();
        end
      end
    end
    for (int i = 0; i < NI; i++) valid_v[i] = 1'b0;
    repeat (60) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
